// File: rtl/alien_shot_scheduler.sv
// Enemy shot scheduler: picks an armed alien (LFSR start column, round-robin scan),
// rate-limits by frame cooldown and bullets in flight, and issues row/col over valid/ready.
module alien_shot_scheduler #(
  parameter int unsigned NUM_ROWS        = 2,
  parameter int unsigned NUM_COLUMNS     = 4,
  parameter int unsigned MAX_SHOTS       = 2,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_tick,
  input  logic                            enable,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0] armed_matrix,
  output logic                            fire_valid,
  input  logic                            fire_ready,
  output logic [15:0]                     fire_row,
  output logic [15:0]                     fire_col,
  input  logic                            shot_done,
  output logic [3:0]                      active_shots
);

  localparam int unsigned W         = NUM_ROWS * NUM_COLUMNS;
  localparam int unsigned CW        = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [8:0]  NCOLS9    = 9'(NUM_COLUMNS);
  localparam logic [7:0]  LAST_PTR  = 8'(NUM_COLUMNS - 1);
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_SHOTS);
  localparam logic [W-1:0] ONE      = W'(1);

  typedef enum logic [1:0] {IDLE, PICK, ISSUE} state_t;

  state_t        state, state_nx;
  logic [15:0]   lfsr;
  logic [CW-1:0] cooldown;
  logic [7:0]    scan_ptr;
  logic [7:0]    scan_cnt;
  logic [W-1:0]  col_bits;
  logic          col_hit;
  logic [15:0]   hit_row;
  logic [31:0]   tgt_idx;
  logic          target_armed;
  logic          handshake;
  logic          start_pick;

  assign fire_valid = (state == ISSUE);
  assign handshake  = fire_valid & fire_ready;

  // Column scan_ptr lands at bit 0; row r of that column then sits at bit r*NUM_COLUMNS.
  always_comb begin
    col_bits = armed_matrix >> scan_ptr;
    col_hit  = 1'b0;
    hit_row  = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (((col_bits >> (r * NUM_COLUMNS)) & ONE) != '0) begin
        col_hit = 1'b1;
        hit_row = 16'(r);
      end
    end
  end

  always_comb begin
    tgt_idx      = 32'(fire_row) * NUM_COLUMNS + 32'(fire_col);
    target_armed = ((armed_matrix >> tgt_idx) & ONE) != '0;
  end

  always_comb begin
    state_nx   = state;
    start_pick = 1'b0;
    case (state)
      IDLE: begin
        if (enable && cooldown == '0 && active_shots < MAX_CNT && |armed_matrix) begin
          state_nx   = PICK;
          start_pick = 1'b1;
        end
      end
      PICK: begin
        if (!enable)                    state_nx = IDLE;
        else if (col_hit)               state_nx = ISSUE;
        else if (scan_cnt == LAST_PTR)  state_nx = IDLE;
      end
      ISSUE: begin
        // A handshake in the same cycle as an abort still counts as a shot.
        if (handshake)                      state_nx = IDLE;
        else if (!enable || !target_armed)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
      scan_cnt <= '0;
      fire_row <= '0;
      fire_col <= '0;
    end else if (start_pick) begin
      scan_ptr <= (9'(lfsr[7:0]) < NCOLS9) ? lfsr[7:0] : '0;
      scan_cnt <= '0;
    end else if (state == PICK) begin
      if (enable && col_hit) begin
        fire_row <= hit_row;
        fire_col <= 16'(scan_ptr);
      end
      scan_ptr <= (scan_ptr == LAST_PTR) ? '0 : scan_ptr + 8'd1;
      scan_cnt <= scan_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cooldown <= CD_LOAD;
    else if (handshake)                       cooldown <= CD_LOAD;
    else if (frame_tick && cooldown != '0)    cooldown <= cooldown - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          active_shots <= '0;
    else if (handshake && !shot_done)                    active_shots <= active_shots + 4'd1;
    else if (shot_done && !handshake && active_shots != '0) active_shots <= active_shots - 4'd1;
  end

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Bench for alien_shot_scheduler: directed scenarios plus random traffic, checked against
// a transaction-level model (start column from LFSR, first armed column found directly).
module tb_alien_shot_scheduler;

  localparam int unsigned NR  = 2;
  localparam int unsigned NC  = 4;
  localparam int unsigned MS  = 2;
  localparam int unsigned CDF = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int unsigned M_IDLE   = 0;
  localparam int unsigned M_SEARCH = 1;
  localparam int unsigned M_ISSUE  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;
  logic fire_ready = 1'b0;
  logic shot_done = 1'b0;
  logic [NR*NC-1:0] armed_matrix = '0;
  logic fire_valid;
  logic [15:0] fire_row, fire_col;
  logic [3:0] active_shots;

  alien_shot_scheduler #(
    .NUM_ROWS(NR), .NUM_COLUMNS(NC), .MAX_SHOTS(MS),
    .COOLDOWN_FRAMES(CDF), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .armed_matrix(armed_matrix), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_row(fire_row), .fire_col(fire_col), .shot_done(shot_done),
    .active_shots(active_shots)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct { int unsigned row; int unsigned col; } shot_t;
  shot_t exp_q[$];

  logic [15:0] m_lfsr;
  int unsigned m_cd, m_act, m_mode, m_wait, m_trow, m_tcol;

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic bit armed_at(input int unsigned r, input int unsigned c);
    return armed_matrix[r * NC + c];
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_cd   = CDF;
    m_act  = 0;
    m_mode = M_IDLE;
    m_wait = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference behaviour, using pre-edge model values.
  task automatic model_edge();
    bit hs;
    int unsigned s, c, k, found;
    hs = (m_mode == M_ISSUE) && fire_ready;
    case (m_mode)
      M_IDLE: begin
        if (enable && m_cd == 0 && m_act < MS && armed_matrix != '0) begin
          s = int'(m_lfsr[7:0]);
          if (s >= NC) s = 0;
          found = 0;
          for (int unsigned j = 0; j < NC; j++) begin
            c = (s + j) % NC;
            if (!found) begin
              for (int unsigned r = 0; r < NR; r++)
                if (armed_at(r, c)) begin found = 1; m_tcol = c; m_trow = r; k = j; end
            end
          end
          m_wait = k + 1;
          m_mode = M_SEARCH;
        end
      end
      M_SEARCH: begin
        if (!enable) m_mode = M_IDLE;
        else begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode = M_ISSUE;
            exp_q.push_back('{row: m_trow, col: m_tcol});
          end
        end
      end
      default: begin
        if (hs) m_mode = M_IDLE;
        else if (!enable || !armed_at(m_trow, m_tcol)) m_mode = M_IDLE;
      end
    endcase
    if (hs) m_cd = CDF;
    else if (frame_tick && m_cd > 0) m_cd--;
    if (hs && !shot_done) m_act++;
    else if (shot_done && !hs && m_act > 0) m_act--;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("valid_vs_model", fire_valid, (m_mode == M_ISSUE));
    chk("active_vs_model", active_shots, m_act);
  endtask

  task automatic wait_valid(input int unsigned limit, input bit ticks, input string name);
    int unsigned n = 0;
    while (!fire_valid && n < limit) begin
      if (ticks) frame_tick = ~frame_tick;
      step();
      n++;
    end
    frame_tick = 1'b0;
    chk(name, fire_valid, 1);
  endtask

  // Monitor: each new request is matched against the oldest predicted shot.
  initial begin : monitor
    logic prev;
    shot_t e;
    int unsigned hold_row, hold_col;
    prev = 1'b0;
    hold_row = 0;
    hold_col = 0;
    forever begin
      @(negedge clk);
      if (fire_valid && !prev) begin
        chk("expected_shot_queued", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("shot_row", fire_row, e.row);
          chk("shot_col", fire_col, e.col);
          hold_row = e.row;
          hold_col = e.col;
        end
      end else if (fire_valid && prev) begin
        chk("hold_row", fire_row, hold_row);
        chk("hold_col", fire_col, hold_col);
      end
      prev = fire_valid;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int unsigned cnt, idx, other;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", fire_valid, 0);
    chk("reset_active", active_shots, 0);
    chk("reset_row", fire_row, 0);
    chk("reset_col", fire_col, 0);
    rst_n = 1'b1;

    // Cooldown gate: nothing before two frame ticks, then a shot from row 1.
    armed_matrix = '1;
    enable = 1'b1;
    repeat (10) step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    wait_valid(NC + 1, 1'b0, "first_valid_latency");
    chk("first_row", fire_row, 1);
    fire_ready = 1'b1;
    step();

    // Single target at [0][2], ready tied high: counts to MAX_SHOTS and stalls.
    armed_matrix = 8'b0000_0100;
    shot_done = 1'b1; step(); shot_done = 1'b0;
    chk("drained_to_zero", active_shots, 0);
    for (int i = 0; i < 60 && m_act < MS; i++) begin
      frame_tick = (i % 2 == 0); step();
    end
    chk("two_in_flight", active_shots, 2);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      frame_tick = (i % 2 == 0); step(); cnt += fire_valid;
    end
    frame_tick = 1'b0;
    chk("stall_no_valid", cnt, 0);
    chk("stall_count", active_shots, 2);
    shot_done = 1'b1; step(); shot_done = 1'b0;
    chk("after_done", active_shots, 1);
    for (int i = 0; i < 20 && m_act < MS; i++) begin
      frame_tick = (i % 2 == 0); step();
    end
    frame_tick = 1'b0;
    chk("refill_two", active_shots, 2);

    // Backpressure hold, then target killed while issuing.
    fire_ready = 1'b0;
    shot_done = 1'b1; step(); shot_done = 1'b0;
    wait_valid(16, 1'b1, "held_valid_rise");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_valid", fire_valid, 1);
      chk("held_row", fire_row, 0);
      chk("held_col", fire_col, 2);
    end
    armed_matrix = '0;
    step();
    chk("kill_drop", fire_valid, 0);
    chk("kill_count", active_shots, 1);

    // Handshake and shot_done together, then shot_done at zero.
    armed_matrix = 8'b0000_0100;
    wait_valid(16, 1'b1, "e_valid");
    fire_ready = 1'b1; shot_done = 1'b1; step();
    fire_ready = 1'b0;
    chk("hs_and_done", active_shots, 1);
    step();
    chk("done_to_zero", active_shots, 0);
    step();
    chk("done_at_zero", active_shots, 0);
    shot_done = 1'b0;

    // Empty formation for 100 frames, then one alien at [1][3].
    armed_matrix = '0;
    fire_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      frame_tick = (i % 2 == 0); step(); cnt += fire_valid;
    end
    frame_tick = 1'b0;
    chk("empty_no_valid", cnt, 0);
    armed_matrix = 8'b1000_0000;
    wait_valid(NC + 1, 1'b0, "lone_valid");
    chk("lone_row", fire_row, 1);
    chk("lone_col", fire_col, 3);
    step();
    fire_ready = 1'b0;

    // Enable dropped while picking.
    armed_matrix = '1;
    for (int i = 0; i < 20 && m_mode != M_SEARCH; i++) begin
      frame_tick = ~frame_tick; step();
    end
    frame_tick = 1'b0;
    enable = 1'b0;
    cnt = 0;
    repeat (6) begin step(); cnt += fire_valid; end
    chk("pick_abort_no_valid", cnt, 0);
    chk("pick_abort_count", active_shots, 1);
    enable = 1'b1;

    // Reset while issuing.
    wait_valid(16, 1'b1, "h_valid");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", fire_valid, 0);
    chk("rst_active", active_shots, 0);
    chk("rst_row", fire_row, 0);
    chk("rst_col", fire_col, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin step(); cnt += fire_valid; end
    chk("rst_cooldown_reload", cnt, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(3) == 0);
      fire_ready = $urandom_range(1);
      shot_done  = ($urandom_range(5) == 0);
      enable     = ($urandom_range(15) != 0);
      if (m_mode == M_IDLE && m_cd > 0 && $urandom_range(3) == 0) begin
        armed_matrix = 8'($urandom_range(255, 1));
      end else if (m_mode == M_ISSUE && $urandom_range(7) == 0) begin
        idx = m_trow * NC + m_tcol;
        other = (idx + 1 + $urandom_range(NR * NC - 2)) % (NR * NC);
        armed_matrix[idx] = 1'b0;
        armed_matrix[other] = 1'b1;
      end
      step();
    end
    frame_tick = 1'b0; fire_ready = 1'b0; shot_done = 1'b0; enable = 1'b0;
    repeat (3) step();
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
